uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
// - Receive side of the UART link: samples the asynchronous serial line, finds start bits,
//   recovers 8N1 frames LSB-first and delivers each byte in parallel with a 1-cycle strobe.
// - Mirrors the transmit-path serializer, which shifts bit 0 first with an idle level of 1.
// - Sits between the pad/serial input and the byte consumer, such as a FIFO or register file.
// PARAMETERS
// - CLKS_PER_BIT  16  clk cycles per bit period, >=4; elaboration error otherwise
// - DATA_BITS     8   payload bits per frame, fixed 1 stop bit and no parity
// PORTS
// - clk        in   1          single system clock, all logic on posedge
// - reset      in   1          asynchronous, active-high; clears every flop immediately
// - rx_in      in   1          raw serial line, asynchronous to clk, idle level 1
// - rx_data    out  DATA_BITS  last good byte; holds value until next good frame
// - rx_valid   out  1          1-cycle pulse: rx_data updated this cycle
// - frame_err  out  1          1-cycle pulse: stop bit sampled 0, byte discarded
// - busy       out  1          high from start-bit detect until return to IDLE
// BEHAVIOUR
// - Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE, sync flops=1.
// - rx_in passes through a 2-flop synchronizer. All decisions below use the synced value rx_s.
// - bit_cnt is $clog2(CLKS_PER_BIT) bits wide. HALF = CLKS_PER_BIT/2 (integer division).
// - IDLE: when rx_s==0, go to START, clear bit_cnt, set busy=1.
// - START: count to HALF-1, then sample rx_s.
//   - rx_s==0: go to DATA with bit_cnt=0 and idx=0.
//   - rx_s==1 (glitch): go to IDLE with busy=0. No pulse on either output.
// - DATA: every CLKS_PER_BIT cycles (bit_cnt==CLKS_PER_BIT-1), sample rx_s near the bit centre.
//   - Shift right: shreg <= {rx_s, shreg[DATA_BITS-1:1]}, so the first bit received lands in bit 0.
//   - Increment idx. After the DATA_BITS-th sample, go to STOP.
// - STOP: after CLKS_PER_BIT cycles, sample rx_s.
//   - rx_s==1: next cycle rx_data<=shreg and rx_valid=1; go to IDLE, busy=0.
//   - rx_s==0: next cycle frame_err=1 and rx_data is unchanged; go to BREAK.
// - BREAK: stay until rx_s==1, then go to IDLE, busy=0. A held-low line gives exactly one frame_err.
// - rx_valid and frame_err are mutually exclusive and never high for 2 consecutive cycles.
// - Latency: the rx_valid edge comes 2 sync cycles + HALF + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles
//   after the rx_in falling edge, so mid-stop-bit plus 1.
// - Back-to-back frames: a start bit that begins right after the stop-bit sample is detected
//   from IDLE with no lost byte. The stop half-bit after sampling is not waited for.
// - No handshake back-pressure: the consumer must take rx_data on rx_valid or the next byte
//   overwrites it.
// - Reset mid-frame clears everything asynchronously. On release the receiver is in IDLE, and a
//   line already low is treated as a start edge.
// STRUCTURE
// - Package uart_pkg:
//   - typedef enum rx_state_t {IDLE, START, DATA, STOP, BREAK}
//   - localparams IDLE_LEVEL=1'b1, DEF_CLKS_PER_BIT=16, DEF_DATA_BITS=8, shared with the TX path.
// - One sub-module, sync_2ff: 2-flop synchronizer, asynchronous reset to 1, reusable for other
//   asynchronous inputs.
// - Top level holds the FSM, bit_cnt, idx, shreg and the output registers. No other hierarchy.
// TESTING (CLKS_PER_BIT=16, DATA_BITS=8, bit period = 16 clk)
// - Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one rx_valid, rx_data=0xA5,
//   frame_err stays 0, busy falls with rx_valid.
// - 4-cycle low glitch on idle line -> back to IDLE after START; no rx_valid or frame_err,
//   rx_data unchanged.
// - Frame 0x3C with stop bit driven 0, held low 40 cycles, then 1 -> one frame_err pulse,
//   rx_data keeps its prior value; next frame 0x81 -> rx_valid with 0x81.
// - Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses, values 0x00 then 0xFF,
//   no frame_err.
// - reset asserted in DATA after 3 bits of 0x5A -> outputs 0 at once; after release, a full
//   0x5A frame -> rx_valid with 0x5A.
// - Sweep: 256 random bytes, plus ±3% bit-period skew on the driver -> every byte received
//   correctly and no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX paths.
// Line levels, default framing and receiver state encoding.
package uart_pkg;

  localparam logic IDLE_LEVEL       = 1'b1;
  localparam int   DEF_CLKS_PER_BIT = 16;
  localparam int   DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Flops reset to RST_VAL so an idle line reads as idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver: start-bit hunt, mid-bit sampling,
// LSB-first deserialisation, one-cycle valid/error strobes.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 2) begin : g_bad_cfg
    $error("uart_rx_deserializer: CLKS_PER_BIT>=4, DATA_BITS>=2");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(
    .RST_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (rx_in),
    .q_o   (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_s != IDLE_LEVEL) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          // a start bit gone high by mid-bit was a glitch
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 16 clk/bit.
// Frames are driven on the serial line; strobes are logged.
module tb_uart_rx_deserializer;

  localparam int BP = 160;

  logic       clk;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_deserializer #(
    .CLKS_PER_BIT (16),
    .DATA_BITS    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;

  int unsigned cyc;
  always @(posedge clk) cyc++;

  logic [7:0]  rxq[$];
  int unsigned vcyc[$];
  int unsigned ferr_n;
  int unsigned busy_at_valid;
  int unsigned busy_seen;
  int unsigned pulse_viol;
  logic        prev_pulse;

  initial begin
    ferr_n        = 0;
    busy_at_valid = 0;
    busy_seen     = 0;
    pulse_viol    = 0;
    prev_pulse    = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        rxq.push_back(rx_data);
        vcyc.push_back(cyc);
        if (busy) busy_at_valid++;
      end
      if (frame_err) ferr_n++;
      if (rx_valid && frame_err) pulse_viol++;
      if ((rx_valid || frame_err) && prev_pulse) pulse_viol++;
      if (busy) busy_seen++;
      prev_pulse = rx_valid || frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic check(input string tag,
                       input int unsigned got,
                       input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned rxat(input int i);
    if (i < rxq.size()) return rxq[i];
    return 32'hDEAD;
  endfunction

  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input int bp);
    rx_in = 1'b0;
    #(bp);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      #(bp);
    end
    rx_in = stop;
    #(bp);
  endtask

  int unsigned base;
  int unsigned fall;
  int unsigned bs0;
  logic [7:0]  expq[$];
  logic [7:0]  b;
  int          bp;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 clean frame, with latency from line fall
    base = rxq.size();
    fall = cyc;
    send_frame(8'hA5, 1'b1, BP);
    repeat (20) @(negedge clk);
    check("a5_count", rxq.size() - base, 1);
    check("a5_data", rxat(base), 8'hA5);
    check("a5_out", rx_data, 8'hA5);
    if (vcyc.size() > base)
      check("a5_latency", vcyc[base] - fall, 2 + 8 + 9 * 16 + 1);
    else
      check("a5_latency", 0, 2 + 8 + 9 * 16 + 1);
    check("a5_ferr", ferr_n, 0);
    check("a5_busy_at_valid", busy_at_valid, 0);
    check("a5_busy_idle", busy, 0);

    // 4-cycle glitch
    base = rxq.size();
    bs0 = busy_seen;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (30) @(negedge clk);
    check("gl_busy_seen", busy_seen > bs0, 1);
    check("gl_busy_idle", busy, 0);
    check("gl_count", rxq.size() - base, 0);
    check("gl_ferr", ferr_n, 0);
    check("gl_data", rx_data, 8'hA5);

    // bad stop bit, line held low
    base = rxq.size();
    send_frame(8'h3C, 1'b0, BP);
    repeat (40) @(negedge clk);
    check("brk_busy", busy, 1);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    check("brk_ferr", ferr_n, 1);
    check("brk_count", rxq.size() - base, 0);
    check("brk_data", rx_data, 8'hA5);
    check("brk_busy_idle", busy, 0);
    send_frame(8'h81, 1'b1, BP);
    repeat (20) @(negedge clk);
    check("r81_count", rxq.size() - base, 1);
    check("r81_data", rx_data, 8'h81);

    // back-to-back
    base = rxq.size();
    send_frame(8'h00, 1'b1, BP);
    send_frame(8'hFF, 1'b1, BP);
    repeat (20) @(negedge clk);
    check("b2b_count", rxq.size() - base, 2);
    check("b2b_first", rxat(base), 8'h00);
    check("b2b_second", rxat(base + 1), 8'hFF);
    check("b2b_ferr", ferr_n, 1);

    // reset in the middle of 0x5A after three data bits
    base = rxq.size();
    rx_in = 1'b0;
    #(BP);
    rx_in = 1'b0;
    #(BP);
    rx_in = 1'b1;
    #(BP);
    rx_in = 1'b0;
    #(BP);
    rx_in = 1'b1;
    #(BP / 2);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", rx_valid, 0);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b1, BP);
    repeat (20) @(negedge clk);
    check("rst5a_count", rxq.size() - base, 1);
    check("rst5a_data", rx_data, 8'h5A);

    // 256 random bytes with -3%/0/+3% period skew
    base = rxq.size();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      expq.push_back(b);
      bp = (i % 3 == 0) ? 155 : (i % 3 == 1) ? 160 : 165;
      send_frame(b, 1'b1, bp);
      #20;
    end
    repeat (40) @(negedge clk);
    check("sw_count", rxq.size() - base, 256);
    for (int i = 0; i < 256; i++)
      check($sformatf("sw_byte%0d", i), rxat(base + i), expq[i]);
    check("sw_ferr", ferr_n, 1);
    check("pulse_excl", pulse_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
